// File: rtl/lif_pkg.sv
// Shared defaults for the LIF neuron array (channel count, data width, refractory length).
package lif_pkg;
  localparam int N_CH_DEF   = 4;
  localparam int W_DEF      = 8;
  localparam int REFRAC_DEF = 3;
  localparam int LEAK_W     = 3;
  localparam int MAX_CH     = 8;
  localparam int REF_W      = 4;
endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire channel: shift leak, saturating integrate, threshold fire.
// Refractory hold is built only when LIF_REFRACTORY_EN is defined.
module lif_cell
  import lif_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int REFRAC = REFRAC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_i,
  input  logic              spike_i,
  input  logic [W-1:0]      weight_i,
  input  logic [W-1:0]      threshold_i,
  input  logic [LEAK_W-1:0] leak_shift_i,
  output logic              spike_o,
  output logic [W-1:0]      mem_d_o
);

  logic [W-1:0] v_q, v_d;
  logic         spike_q, spike_d;
  logic [W-1:0] leak;
  logic [W:0]   sum;
  logic [W-1:0] v_sat;
  logic         fire;

  // v - leak never underflows, so one extra bit is enough to detect overflow.
  always_comb begin
    leak  = (leak_shift_i == '0) ? '0 : (v_q >> leak_shift_i);
    sum   = {1'b0, v_q} - {1'b0, leak} + (spike_i ? {1'b0, weight_i} : '0);
    v_sat = sum[W] ? '1 : sum[W-1:0];
    fire  = (threshold_i != '0) && (v_sat >= threshold_i);
  end

`ifdef LIF_REFRACTORY_EN
  logic [REF_W-1:0] ref_q, ref_d;

  always_comb begin
    v_d     = v_q;
    ref_d   = ref_q;
    spike_d = 1'b0;
    if (ena_i) begin
      if (ref_q != '0) begin
        v_d   = '0;
        ref_d = ref_q - 1'b1;
      end else if (fire) begin
        v_d     = '0;
        ref_d   = REF_W'(REFRAC);
        spike_d = 1'b1;
      end else begin
        v_d = v_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_q <= '0;
    else        ref_q <= ref_d;
  end
`else
  always_comb begin
    v_d     = v_q;
    spike_d = 1'b0;
    if (ena_i) begin
      if (fire) begin
        v_d     = '0;
        spike_d = 1'b1;
      end else begin
        v_d = v_sat;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;
  assign mem_d_o = v_d;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N_CH independent LIF channels with a registered membrane readout mux.
// Optional refractory period enabled by defining LIF_REFRACTORY_EN.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int W      = W_DEF,
  parameter int REFRAC = REFRAC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [N_CH-1:0]   spike_in,
  input  logic [W-1:0]      weight,
  input  logic [W-1:0]      threshold,
  input  logic [LEAK_W-1:0] leak_shift,
  input  logic [2:0]        mem_sel,
  output logic [N_CH-1:0]   spike_out,
  output logic [W-1:0]      mem_out
);

  // Padded to the full mem_sel range so out-of-range selects read as zero.
  logic [MAX_CH-1:0][W-1:0] mem_all;
  logic [W-1:0]             mem_out_q, mem_out_d;

  for (genvar i = 0; i < MAX_CH; i++) begin : g_ch
    if (i < N_CH) begin : g_cell
      lif_cell #(
        .W      (W),
        .REFRAC (REFRAC)
      ) u_cell (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena_i        (ena),
        .spike_i      (spike_in[i]),
        .weight_i     (weight),
        .threshold_i  (threshold),
        .leak_shift_i (leak_shift),
        .spike_o      (spike_out[i]),
        .mem_d_o      (mem_all[i])
      );
    end else begin : g_pad
      assign mem_all[i] = '0;
    end
  end

  assign mem_out_d = mem_all[mem_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_out_q <= '0;
    else        mem_out_q <= mem_out_d;
  end

  assign mem_out = mem_out_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboarded bench: directed scenarios plus random steps against an arithmetic reference model.
module tb_lif_neuron_array;
  localparam int NCH = 4;
  localparam int WW  = 8;
  localparam int RFR = 3;
`ifdef LIF_REFRACTORY_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b0;
  logic [NCH-1:0] spike_in = '0;
  logic [WW-1:0]  weight = '0;
  logic [WW-1:0]  threshold = '0;
  logic [2:0]     leak_shift = '0;
  logic [2:0]     mem_sel = '0;
  logic [NCH-1:0] spike_out;
  logic [WW-1:0]  mem_out;

  lif_neuron_array #(.N_CH(NCH), .W(WW), .REFRAC(RFR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_in   (spike_in),
    .weight     (weight),
    .threshold  (threshold),
    .leak_shift (leak_shift),
    .mem_sel    (mem_sel),
    .spike_out  (spike_out),
    .mem_out    (mem_out)
  );

  always #5 clk = ~clk;

  int v [NCH];
  int rc[NCH];
  logic [NCH+WW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int step_no = 0;

  always @(negedge clk) begin
    logic [NCH+WW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (spike_out !== e[NCH+WW-1:WW]) begin
        n_err++;
        $display("FAIL spike_out step %0d: got %b expected %b", step_no, spike_out, e[NCH+WW-1:WW]);
      end
      n_cmp++;
      if (mem_out !== e[WW-1:0]) begin
        n_err++;
        $display("FAIL mem_out step %0d (sel %0d): got %0d expected %0d", step_no, mem_sel, mem_out, e[WW-1:0]);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      v[c] = 0; rc[c] = 0;
    end
    #1;
    n_cmp++;
    if (spike_out !== '0 || mem_out !== '0) begin
      n_err++;
      $display("FAIL async_reset: got spike %b mem %0d expected 0 0", spike_out, mem_out);
    end
    exp_q.push_back('0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic e, input logic [NCH-1:0] s, input logic [WW-1:0] w,
                      input logic [WW-1:0] th, input logic [2:0] ls, input logic [2:0] sel);
    logic [NCH-1:0] sp;
    int nv, mo;
    ena = e; spike_in = s; weight = w; threshold = th; leak_shift = ls; mem_sel = sel;
    @(posedge clk);
    step_no++;
    sp = '0;
    if (e) begin
      for (int c = 0; c < NCH; c++) begin
        if (REF_EN && rc[c] > 0) begin
          v[c] = 0;
          rc[c] = rc[c] - 1;
        end else begin
          nv = v[c] - ((ls == 0) ? 0 : (v[c] >> ls)) + (s[c] ? int'(w) : 0);
          if (nv > 255) nv = 255;
          if (th != 0 && nv >= int'(th)) begin
            nv = 0;
            sp[c] = 1'b1;
            rc[c] = RFR;
          end
          v[c] = nv;
        end
      end
    end
    mo = (int'(sel) < NCH) ? v[sel] : 0;
    exp_q.push_back({sp, WW'(mo)});
    @(negedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // fire at 30 then refractory or immediate re-integration
    for (int k = 0; k < 7; k++) step(1, 4'b0001, 8'd10, 8'd30, 3'd0, 3'd0);

    // saturation with firing disabled
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 4'b0010, 8'd200, 8'd0, 3'd0, 3'd1);

    // leak halving after a single pulse
    do_reset();
    step(1, 4'b0100, 8'd128, 8'd255, 3'd1, 3'd2);
    for (int k = 0; k < 4; k++) step(1, 4'b0000, 8'd128, 8'd255, 3'd1, 3'd2);

    // all channels fire together
    do_reset();
    step(1, 4'b1111, 8'd30, 8'd30, 3'd0, 3'd3);
    for (int k = 0; k < 4; k++) step(0, 4'b1111, 8'd30, 8'd30, 3'd0, 3'(k));

    // ena hold, then reset in the middle of refractory
    do_reset();
    step(1, 4'b0001, 8'd10, 8'd30, 3'd0, 3'd0);
    step(1, 4'b0001, 8'd10, 8'd30, 3'd0, 3'd0);
    for (int k = 0; k < 5; k++) step(0, 4'($urandom_range(0, 15)), 8'd10, 8'd30, 3'd0, 3'd0);
    step(1, 4'b0001, 8'd10, 8'd30, 3'd0, 3'd0);
    step(1, 4'b0001, 8'd10, 8'd30, 3'd0, 3'd0);
    do_reset();
    step(1, 4'b0001, 8'd10, 8'd30, 3'd0, 3'd0);
    step(1, 4'b0001, 8'd10, 8'd30, 3'd0, 3'd0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(($urandom_range(0, 9) != 0),
           4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
           3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)));
    end

    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
